axi_slave_mem_responder: RTL and testbench

AXI slave-side responder backed by a word-addressed memory. It is the target end of the NOC master ports and terminates an AXI slave port (S0-S6) in block-level and NOC benches. It accepts write and read bursts (FIXED/INCR/WRAP, 4-bit len, up to 32-bit beats) with programmable address-accept wait states. It returns OKAY or SLVERR responses that carry the request ID.

---
 rtl/axi_noc_pkg.sv | 38 +++
 rtl/axi_burst_addr_gen.sv | 49 ++++
 rtl/axi_slave_mem_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_slave_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_noc_pkg.sv
// Shared AXI types and burst address arithmetic for the NOC slave responders.
package axi_noc_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  typedef logic [63:0] axi_addr_t;

  // Next beat address; WRAP assumes a power-of-two block (illegal lens are flagged elsewhere).
  function automatic axi_addr_t axi_next_addr(axi_addr_t addr, logic [3:0] len,
                                              logic [2:0] size, burst_t burst);
    axi_addr_t step, bytes, nxt, res;
    step  = axi_addr_t'(1) << size;
    bytes = (axi_addr_t'(len) + axi_addr_t'(1)) << size;
    nxt   = (addr & ~(step - axi_addr_t'(1))) + step;
    case (burst)
      BURST_INCR: res = nxt;
      BURST_WRAP: res = (addr & ~(bytes - axi_addr_t'(1))) | (nxt & (bytes - axi_addr_t'(1)));
      default:    res = addr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-channel burst address tracker: holds current address and beat, exposes next address.
module axi_burst_addr_gen
  import axi_noc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [3:0]        len_in,
  input  logic [2:0]        size_in,
  input  burst_t            burst_in,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_nxt,
  output logic              last,
  output logic              last_nxt
);

  logic [3:0] len_q;
  logic [2:0] size_q;
  burst_t     burst_q;
  logic [3:0] beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      beat_q  <= '0;
    end else if (load) begin
      addr    <= addr_in;
      len_q   <= len_in;
      size_q  <= size_in;
      burst_q <= burst_in;
      beat_q  <= '0;
    end else if (advance) begin
      addr   <= addr_nxt;
      beat_q <= beat_q + 4'd1;
    end
  end

  assign addr_nxt = ADDR_W'(axi_next_addr(axi_addr_t'(addr), len_q, size_q, burst_q));
  assign last     = (beat_q == len_q);
  assign last_nxt = ((beat_q + 4'd1) == len_q);

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI slave terminating a port into a word-addressed memory; independent write and read FSMs.
//   state  | meaning
//   W_IDLE | count accept wait states, then raise awready and capture AW
//   W_DATA | wready high, commit strobed bytes per beat
//   W_RESP | bvalid held with bid/bresp until bready
//   R_IDLE | count accept wait states, then raise arready; first beat loaded on accept
//   R_DATA | rvalid high, next beat loaded on each R handshake
module axi_slave_mem_responder
  import axi_noc_pkg::*;
#(
  parameter int                ID_W       = 6,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                MEM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                ACCEPT_DLY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic [3:0]          awqos,
  input  logic [3:0]          awregion,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic [3:0]          arqos,
  input  logic [3:0]          arregion,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int         IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] DLY   = 4'(ACCEPT_DLY);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Whole-transaction error: checks the lowest and highest byte any beat can touch.
  function automatic logic calc_err(logic [ADDR_W-1:0] a, logic [3:0] len,
                                    logic [2:0] size, logic [1:0] burst);
    logic [63:0] a64, lo, hi, step, bytes;
    logic        bad;
    a64   = 64'(a);
    step  = 64'd1 << size;
    bytes = (64'(len) + 64'd1) << size;
    bad   = (size > 3'd2);
    case (burst_t'(burst))
      BURST_FIXED: begin lo = a64; hi = a64; end
      BURST_INCR: begin
        lo = a64;
        hi = (a64 & ~(step - 64'd1)) + (64'(len) << size);
      end
      BURST_WRAP: begin
        lo  = a64 & ~(bytes - 64'd1);
        hi  = lo + bytes - 64'd1;
        bad = bad | !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
      end
      default: begin lo = a64; hi = a64; bad = 1'b1; end
    endcase
    return bad || (lo < 64'(BASE_ADDR)) ||
           (((hi - 64'(BASE_ADDR)) >> 2) >= 64'(MEM_DEPTH));
  endfunction

  logic unused_sig;
  assign unused_sig = ^{awlock, awcache, awprot, awqos, awregion,
                        arlock, arcache, arprot, arqos, arregion};

  // ---------------- write channel ----------------
  wr_state_t         w_state;
  logic [3:0]        aw_cnt;
  logic              w_err;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_addr_nxt_unused;
  logic              w_last, w_last_nxt_unused;
  logic              aw_hs, w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr (
    .clk(clk), .rst(rst), .load(aw_hs), .advance(w_hs),
    .addr_in(awaddr), .len_in(awlen), .size_in(awsize), .burst_in(burst_t'(awburst)),
    .addr(w_addr), .addr_nxt(w_addr_nxt_unused), .last(w_last), .last_nxt(w_last_nxt_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_cnt  <= DLY;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_err   <= 1'b0;
      w_id    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awready <= 1'b0;
            aw_cnt  <= DLY;
            w_id    <= awid;
            w_err   <= calc_err(awaddr, awlen, awsize, awburst);
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else if (awvalid) begin
            if (aw_cnt == 4'd0) awready <= 1'b1;
            else                aw_cnt  <= aw_cnt - 4'd1;
          end
        end
        W_DATA: begin
          if (w_hs && (wlast || w_last)) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bid     <= w_id;
            bresp   <= (w_err || (wlast != w_last)) ? RESP_SLVERR : RESP_OKAY;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         r_state;
  logic [3:0]        ar_cnt;
  logic              r_err, ar_err;
  logic [ADDR_W-1:0] r_addr_unused, r_addr_nxt;
  logic              r_last_unused, r_last_nxt;
  logic              ar_hs, r_hs;

  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign ar_err = calc_err(araddr, arlen, arsize, arburst);

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr (
    .clk(clk), .rst(rst), .load(ar_hs), .advance(r_hs),
    .addr_in(araddr), .len_in(arlen), .size_in(arsize), .burst_in(burst_t'(arburst)),
    .addr(r_addr_unused), .addr_nxt(r_addr_nxt), .last(r_last_unused), .last_nxt(r_last_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      ar_cnt  <= DLY;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            ar_cnt  <= DLY;
            rid     <= arid;
            r_err   <= ar_err;
            rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata   <= ar_err ? '0 : mem[word_idx(araddr)];
            rlast   <= (arlen == 4'd0);
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end else if (arvalid) begin
            if (ar_cnt == 4'd0) arready <= 1'b1;
            else                ar_cnt  <= ar_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              rdata <= r_err ? '0 : mem[word_idx(r_addr_nxt)];
              rlast <= r_last_nxt;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed bench: queue-based response model plus literal checks on key read-backs.
module tb_axi_slave_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_slave_mem_responder #(
    .ID_W(6), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024),
    .BASE_ADDR(32'h0), .ACCEPT_DLY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(1'b0), .awcache(4'h0), .awprot(3'h0), .awqos(4'h0), .awregion(4'h0),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(1'b0), .arcache(4'h0), .arprot(3'h0), .arqos(4'h0), .arregion(4'h0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [5:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] mdl [1024];
  logic [31:0] rx_data [16];
  logic        rx_last [16];
  int          rx_n;
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];

  // Byte address of beat i, from the burst rules directly.
  function automatic longint beat_addr(longint a, int len, int size, int burst, int i);
    longint step, bytes, base;
    step = longint'(1) << size;
    if (burst == 0) return a;
    if (burst == 1) return (i == 0) ? a : (a / step) * step + i * step;
    bytes = (len + 1) * step;
    base  = (a / bytes) * bytes;
    return base + ((a - base + i * step) % bytes);
  endfunction

  function automatic bit model_err(longint a, int len, int size, int burst);
    if (size > 2 || burst == 3) return 1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1;
    for (int i = 0; i <= len; i++)
      if ((beat_addr(a, len, size, burst, i) >> 2) >= 1024) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid) begin
        if (bq.size() == 0) check("b_unexpected", bvalid, 0);
        else begin
          check("b_id", bid, bq[0].id);
          check("b_resp", bresp, bq[0].resp);
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) check("r_unexpected", rvalid, 0);
        else begin
          check("r_id", rid, rq[0].id);
          check("r_data", rdata, rq[0].data);
          check("r_resp", rresp, rq[0].resp);
          check("r_last", rlast, rq[0].last);
          if (rready) begin
            if (rx_n < 16) begin
              rx_data[rx_n] = rdata;
              rx_last[rx_n] = rlast;
              rx_n++;
            end
            void'(rq.pop_front());
          end
        end
      end
    end
  end

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int wlast_beat, input int bdly);
    int     nb, n;
    bit     err, proto;
    b_exp_t be;
    longint w;
    nb    = (wlast_beat <= len) ? wlast_beat + 1 : len + 1;
    err   = model_err(addr, len, size, burst);
    proto = (wlast_beat != len);
    be.id   = id;
    be.resp = (err || proto) ? 2'b10 : 2'b00;
    bq.push_back(be);
    if (!err) begin
      for (int b = 0; b < nb; b++) begin
        w = beat_addr(addr, len, size, burst, b) >> 2;
        for (int k = 0; k < 4; k++)
          if (sbuf[b][k]) mdl[int'(w)][8*k +: 8] = wbuf[b][8*k +: 8];
      end
    end
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 40) begin n++; @(negedge clk); end
    check("aw_accept_cycles", n, 4);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == wlast_beat); wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 20) begin n++; @(negedge clk); end
      if (!wready) check("w_ready_timeout", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("b_valid_next_cycle", bvalid, 1);
    repeat (bdly + 1) @(posedge clk);
    #1 bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin n++; @(negedge clk); end
    if (!bvalid) check("b_timeout", bvalid, 1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input logic [3:0] pat, input int rst_after);
    int     n, got, cyc;
    bit     err;
    r_exp_t re;
    err = model_err(addr, len, size, burst);
    for (int i = 0; i <= len; i++) begin
      re.id   = id;
      re.data = err ? 32'h0 : mdl[int'(beat_addr(addr, len, size, burst, i) >> 2)];
      re.resp = err ? 2'b10 : 2'b00;
      re.last = (i == len);
      rq.push_back(re);
    end
    rx_n = 0;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 40) begin n++; @(negedge clk); end
    check("ar_accept_cycles", n, 4);
    @(posedge clk); #1;
    arvalid = 1'b0;
    got = 0; cyc = 0;
    while (got <= len && cyc < 100) begin
      if (rst_after >= 0 && got == rst_after) begin
        #2 rst = 1'b1;
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        rq.delete();
        rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      rready = pat[cyc % 4];
      @(negedge clk);
      if (rvalid && rready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    check("r_beat_count", got, len + 1);
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_valid", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
    check("rst_b_fields", {bid, bresp}, 0);
    check("rst_r_fields", {rid, rresp, rdata}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
    do_write(6'h15, 32'h10, 3, 2, 1, 3, 0);
    do_read(6'h2A, 32'h10, 3, 2, 1, 4'hF, -1);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata_lit", rx_data[i], 32'hA0 + i);
      check("incr_rlast_lit", rx_last[i], (i == 3));
    end

    // WRAP read order
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE_0030 + 4 * i; sbuf[i] = 4'hF; end
    do_write(6'h01, 32'h30, 3, 2, 1, 3, 0);
    do_read(6'h02, 32'h38, 3, 2, 2, 4'hF, -1);
    wrap_exp = '{32'hC0DE_0038, 32'hC0DE_003C, 32'hC0DE_0030, 32'hC0DE_0034};
    for (int i = 0; i < 4; i++) check("wrap_rdata_lit", rx_data[i], wrap_exp[i]);

    // rready stalls 1-0-0-1
    do_read(6'h03, 32'h10, 3, 2, 1, 4'b1001, -1);
    check("stall_rdata_lit", rx_data[3], 32'hA3);

    // out-of-range write suppressed, read returns zero with SLVERR
    wbuf[0] = 32'h5A5A_0000; sbuf[0] = 4'hF;
    do_write(6'h04, 32'h0, 0, 2, 1, 0, 0);
    wbuf[0] = 32'hDEAD_0001; wbuf[1] = 32'hDEAD_0002;
    do_write(6'h05, 32'h1000, 1, 2, 1, 1, 0);
    do_read(6'h06, 32'h0, 0, 2, 1, 4'hF, -1);
    check("oor_no_alias_lit", rx_data[0], 32'h5A5A_0000);
    do_read(6'h07, 32'h1000, 1, 2, 1, 4'hF, -1);
    check("oor_rdata0_lit", rx_data[0], 32'h0);
    check("oor_rdata1_lit", rx_data[1], 32'h0);

    // last legal words vs one past the end
    wbuf[0] = 32'h0FF8_0FF8; wbuf[1] = 32'h0FFC_0FFC;
    do_write(6'h08, 32'hFF8, 1, 2, 1, 1, 0);
    wbuf[0] = 32'hBAD0_0000; wbuf[1] = 32'hBAD0_0001;
    do_write(6'h09, 32'hFFC, 1, 2, 1, 1, 0);
    do_read(6'h0A, 32'hFF8, 1, 2, 1, 4'hF, -1);
    check("edge_last_word_lit", rx_data[1], 32'h0FFC_0FFC);

    // early wlast with held bready, then missing wlast
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h4400 + i; sbuf[i] = 4'hF; end
    do_write(6'h2B, 32'h40, 3, 2, 1, 1, 5);
    do_read(6'h0B, 32'h40, 1, 2, 1, 4'hF, -1);
    do_write(6'h0C, 32'h60, 1, 2, 1, 9, 0);

    // byte lanes with FIXED size-0 burst
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
    do_write(6'h12, 32'h50, 0, 2, 1, 0, 0);
    wbuf[0] = 32'h0000_AB00; wbuf[1] = 32'h0000_CD00; sbuf[0] = 4'b0010; sbuf[1] = 4'b0010;
    do_write(6'h13, 32'h51, 1, 0, 0, 1, 0);
    do_read(6'h14, 32'h50, 0, 2, 1, 4'hF, -1);
    check("byte_lane_lit", rx_data[0], 32'h1122_CD44);

    // illegal size / burst / wrap length
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    do_write(6'h0D, 32'h20, 0, 3, 1, 0, 0);
    do_read(6'h0E, 32'h10, 1, 2, 3, 4'hF, -1);
    do_read(6'h0F, 32'h30, 2, 2, 2, 4'hF, -1);

    // reset in the middle of a read burst
    do_read(6'h10, 32'h10, 3, 2, 1, 4'hF, 2);
    do_read(6'h11, 32'h10, 3, 2, 1, 4'hF, -1);
    check("post_rst_rdata0_lit", rx_data[0], 32'hA0);
    check("post_rst_rdata3_lit", rx_data[3], 32'hA3);

    repeat (3) @(posedge clk);
    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got %0d errors of %0d checks so far, expected completion", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
